// File: rtl/phy_pkg.sv
// Shared PHY definitions used by the receive lane synchronizer and the
// transmit-side serializer.
//   COM / IDL       : comma/training and idle characters
//   syncState_t     : receive synchronizer state encoding
//   isControl()     : true for characters that are never forwarded as data
package phy_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    localparam logic [1:0] SEARCH_ENC = 2'd0;
    localparam logic [1:0] ALIGN_ENC  = 2'd1;
    localparam logic [1:0] LOCKED_ENC = 2'd2;

    typedef enum logic [1:0] {
        SEARCH = SEARCH_ENC,
        ALIGN  = ALIGN_ENC,
        LOCKED = LOCKED_ENC
    } syncState_t;

    function automatic logic isControl(input logic [7:0] b);
        return (b == COM) || (b == IDL);
    endfunction

endpackage

// File: rtl/phy_shift_in.sv
// Serial-to-parallel front end of the lane synchronizer.
// Ports:
//   clk      in   bit-rate clock
//   rstN     in   asynchronous active-low reset
//   serialIn in   serial data, MSB first
//   clearCnt in   synchronous clear of the bit counter
//   window   out  8-bit byte window including the bit being sampled now
//   bitCnt   out  position within the current byte (0..7, wraps)
module phy_shift_in (
    input  logic       clk,
    input  logic       rstN,
    input  logic       serialIn,
    input  logic       clearCnt,
    output logic [7:0] window,
    output logic [2:0] bitCnt
);

    // The byte shift register is 8 bits wide, but its oldest bit is shifted
    // out on the same edge it would be compared, so only the 7 youngest bits
    // are stored; the live serial input supplies the 8th window bit.
    logic [6:0] histReg;

    assign window = {histReg, serialIn};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            histReg <= '0;
            bitCnt  <= '0;
        end else begin
            histReg <= window[6:0];
            bitCnt  <= clearCnt ? 3'd0 : bitCnt + 3'd1;
        end
    end

endmodule

// File: rtl/phy_rx_lane_sync.sv
// Receive-side lane synchronizer. Hunts for COM at any bit offset, locks
// byte alignment after LOCK_CNT consecutive aligned COMs, then forwards
// aligned data bytes (COM/IDL are dropped).
// Ports:
//   clk_32f      in   bit-rate clock, rising edge
//   reset        in   asynchronous active-low reset
//   serial_in    in   serial data, MSB first
//   data_out     out  last aligned data byte (held between boundaries)
//   valid_out    out  data_out holds a data byte
//   byte_strobe  out  one-cycle pulse on each aligned byte boundary
//   active       out  lane locked; sticky until reset
module phy_rx_lane_sync
    import phy_pkg::*;
#(
    parameter int LOCK_CNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

    syncState_t state, stateNext;
    logic [3:0] comCnt, comCntNext;
    logic [7:0] window;
    logic [2:0] bitCnt;
    logic       clearCnt;
    logic       boundary;
    logic [7:0] dataNext;
    logic       validNext, strobeNext, activeNext;

    // While searching, the counter is pinned at 0 so that the edge finding
    // COM leaves it at 0 and the next boundary lands exactly 8 edges later.
    assign clearCnt = (state == SEARCH);
    assign boundary = (bitCnt == 3'd7);

    phy_shift_in u_shiftIn (
        .clk      (clk_32f),
        .rstN     (reset),
        .serialIn (serial_in),
        .clearCnt (clearCnt),
        .window   (window),
        .bitCnt   (bitCnt)
    );

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state       <= SEARCH;
            comCnt      <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= stateNext;
            comCnt      <= comCntNext;
            data_out    <= dataNext;
            valid_out   <= validNext;
            byte_strobe <= strobeNext;
            active      <= activeNext;
        end
    end

    always_comb begin
        stateNext  = state;
        comCntNext = comCnt;
        dataNext   = data_out;
        validNext  = valid_out;
        strobeNext = 1'b0;
        activeNext = active;
        case (state)
            SEARCH: begin
                if (window == COM) begin
                    stateNext  = ALIGN;
                    comCntNext = 4'd1;
                    strobeNext = 1'b1;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    strobeNext = 1'b1;
                    if (window == COM) begin
                        comCntNext = comCnt + 4'd1;
                        if (comCnt + 4'd1 == LOCK_TARGET) begin
                            stateNext  = LOCKED;
                            activeNext = 1'b1;
                        end
                    end else begin
                        // Broken run: the hunt resumes on the next edge.
                        comCntNext = 4'd0;
                        stateNext  = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    strobeNext = 1'b1;
                    if (isControl(window)) begin
                        validNext = 1'b0;
                    end else begin
                        dataNext  = window;
                        validNext = 1'b1;
                    end
                end
            end
            default: stateNext = SEARCH;
        endcase
    end

endmodule

// File: doc/phy_rx_lane_sync.md
Name: phy_rx_lane_sync

Overview:
- Receive-side lane synchronizer for the PHY serial link.
- Takes the raw MSB-first bit stream on the bit-rate clock and searches for the COM character (0xBC) at any bit offset.
- Locks byte alignment after a run of consecutive COMs, then delivers aligned data bytes with a valid flag and an active indication.
- Sits between the serial line and the lane un-striping logic. Its active output is what the transmit side uses to leave its COM/IDLE training phase.

Parameters:
- COM, 8'hBC, comma/training character; also the alignment pattern.
- IDL, 8'h7C, idle character; never forwarded as data.
- LOCK_CNT, 4, consecutive aligned COMs required to declare lock (range 2..15).

Ports:
- clk_32f  in  1  bit-rate clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- serial_in  in  1  serial data, MSB first, sampled on rising edge of clk_32f.
- data_out  out  8  last aligned data byte.
- valid_out  out  1  data_out holds a data byte (not COM/IDL).
- byte_strobe  out  1  one-cycle pulse on each aligned byte boundary (ALIGN/LOCKED only).
- active  out  1  lane locked; sticky until reset.

Behaviour:
Reset:
- reset=0 asynchronously clears shift_reg=0, bit_cnt=0, com_cnt=0, state=SEARCH, data_out=0, valid_out=0, byte_strobe=0, active=0.
- Reset mid-stream discards any partial byte and any lock.
- A shift_reg of 0 can never match COM.

Byte window and latency:
- Every edge: shift_reg <= {shift_reg[6:0], serial_in}.
- The window compared on an edge is next = {shift_reg[6:0], serial_in}.
- Outputs update on the same edge that samples the byte's 8th bit (zero extra latency).

State SEARCH:
- Compare next against COM on every edge.
- On match: bit_cnt <= 0, com_cnt <= 1, go to ALIGN, byte_strobe=1 for that cycle.
- Otherwise stay; byte_strobe=0.

State ALIGN:
- bit_cnt increments 0..7 and wraps.
- Boundary is the edge where bit_cnt==7. At the boundary: byte_strobe=1, then evaluate next:
  - next==COM and com_cnt+1==LOCK_CNT: go to LOCKED, active <= 1.
  - next==COM otherwise: com_cnt <= com_cnt+1.
  - Any other value (including IDL): com_cnt <= 0, go to SEARCH. The search restarts on the following edge.
- valid_out stays 0 throughout ALIGN.

State LOCKED:
- bit_cnt continues wrapping; byte_strobe pulses at every boundary.
- At a boundary:
  - next==COM or next==IDL: valid_out <= 0; data_out holds its prior value.
  - Any other byte: data_out <= next, valid_out <= 1.
- data_out and valid_out are held between boundaries for 8 cycles, so slower-clock consumers can sample them.
- Lock is never dropped; only reset exits LOCKED.

Widths and timing:
- bit_cnt is 3 bits, com_cnt is 4 bits.
- active rises exactly 8*(LOCK_CNT-1) cycles after the edge that found the first COM.

Decomposition:
- Shared package phy_pkg:
  - COM/IDL constants, shared with the transmit-side serializer.
  - State encoding localparams: SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2.
- Optional sub-module phy_shift_in: 8-bit shift register plus 3-bit bit counter with a sync-clear input.
- The FSM and output registers stay in phy_rx_lane_sync.

Test Plan:
- Reset held low for 3 cycles with serial_in toggling -> all outputs 0, state SEARCH; release, then send 4 aligned COMs (32 bits) -> active rises on the 32nd bit edge, valid_out=0.
- Prefix of 3 bits 1,0,1, then 4 COMs -> lock acquired at the offset alignment; byte_strobe period 8 from the first COM match.
- COM, COM, COM, 0x55 -> returns to SEARCH at the 4th boundary, active stays 0; 4 further COMs -> active=1.
- Locked, then 0xA5, 0x3C, IDL -> data_out=0xA5 valid=1 for 8 cycles, then 0x3C valid=1, then valid=0 with data_out holding 0x3C.
- Locked, then COM interleaved between data 0x11 and 0x22 -> valid_out 1,0,1; active stays 1.
- reset asserted mid-byte while locked -> active, valid_out and data_out clear immediately (asynchronously); re-lock requires a full 4-COM sequence.
